// File: rtl/rvfi_trace_capture_if.sv
// Retirement port (RVFI subset) and dump byte-stream handshake shared by a
// core monitor and the trace capture block.
interface rvfi_trace_capture_if;
   logic        rvfi_valid;
   logic [31:0] rvfi_pc_rdata;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic        rvfi_halt;
   logic        rvfi_intr;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, tx_ready,
      input  tx_data, tx_valid
   );

   modport slave (
      input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, tx_ready,
      output tx_data, tx_valid
   );
endinterface

// File: rtl/rvfi_trace_capture.sv
// Circular retirement trace buffer: captures around a trigger, then dumps
// header + records oldest-first as a byte stream for a UART transmitter.
module rvfi_trace_capture #(
   parameter int DEPTH     = 64,
   parameter int POST_TRIG = 16
) (
   input  logic                 sys_clock,
   input  logic                 reset,
   rvfi_trace_capture_if.slave  bus,
   input  logic                 arm,
   input  logic                 force_trig,
   input  logic [2:0]           trig_mask,
   output logic                 armed,
   output logic                 triggered,
   output logic                 busy,
   output logic                 done
);
   localparam int              AW        = $clog2(DEPTH);
   localparam int              RW        = 67;
   localparam logic [15:0]     CNT_FULL  = 16'(DEPTH);
   localparam logic [15:0]     POST_LAST = 16'(POST_TRIG);
   localparam logic [AW-1:0]   PTR_ONE   = AW'(1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARMED = 3'd1;
   localparam logic [2:0] S_POST  = 3'd2;
   localparam logic [2:0] S_DUMP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state;
   logic [RW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] start_ptr;
   logic [15:0]   count;
   logic [15:0]   post_cnt;
   logic [15:0]   recs_left;
   logic          in_hdr;
   logic [1:0]    hdr_pos;
   logic [3:0]    byte_sel;
   logic [3:0]    nxt_sel;
   logic [RW-1:0] rd_rec;
   logic [7:0]    rec_byte;
   logic [2:0]    flags;
   logic          store;
   logic          trig;
   logic          last_post;
   logic          xfer;
   logic          last_byte;

   assign flags     = {bus.rvfi_intr, bus.rvfi_halt, bus.rvfi_trap};
   assign store     = bus.rvfi_valid && (state == S_ARMED || state == S_POST);
   assign trig      = force_trig || (bus.rvfi_valid && (trig_mask & flags) != 3'b000);
   assign last_post = bus.rvfi_valid && (post_cnt + 16'd1 == POST_LAST);
   assign xfer      = bus.tx_valid && bus.tx_ready;
   // When full, count[AW-1:0] is zero and the oldest entry sits at wr_ptr.
   assign start_ptr = wr_ptr - count[AW-1:0];
   assign last_byte = in_hdr ? (count == 16'd0) : (byte_sel == 4'd8 && recs_left == 16'd1);

   // Address and byte lane of the byte that follows the one currently presented.
   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      rd_addr = rd_ptr;
      nxt_sel = byte_sel + 4'd1;
      if (in_hdr) begin
         rd_addr = start_ptr;
         nxt_sel = 4'd0;
      end else if (byte_sel == 4'd8) begin
         rd_addr = rd_ptr + PTR_ONE;
         nxt_sel = 4'd0;
      end
   end

   assign rd_rec = mem[rd_addr];

   always_comb begin
      case (nxt_sel)
         4'd0:    rec_byte = {5'b0, rd_rec[66:64]};
         4'd1:    rec_byte = rd_rec[39:32];
         4'd2:    rec_byte = rd_rec[47:40];
         4'd3:    rec_byte = rd_rec[55:48];
         4'd4:    rec_byte = rd_rec[63:56];
         4'd5:    rec_byte = rd_rec[7:0];
         4'd6:    rec_byte = rd_rec[15:8];
         4'd7:    rec_byte = rd_rec[23:16];
         4'd8:    rec_byte = rd_rec[31:24];
         default: rec_byte = 8'h00;
      endcase
   end

   // NOTE: the trace array has no reset; a dump only reads entries written since the last arm.
   always_ff @(posedge sys_clock) begin
      if (store) mem[wr_ptr] <= {flags, bus.rvfi_pc_rdata, bus.rvfi_insn};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sys_clock) begin
      if (reset) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         post_cnt     <= '0;
         recs_left    <= '0;
         in_hdr       <= 1'b0;
         hdr_pos      <= '0;
         byte_sel     <= '0;
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= 8'h00;
      end else begin
         if (store) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            if (count != CNT_FULL) count <= count + 16'd1;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state    <= S_ARMED;
                  count    <= '0;
                  post_cnt <= '0;
               end
            end
            S_ARMED, S_POST: begin
               // Header byte goes out on the same edge the last record is stored.
               if ((state == S_ARMED && trig && POST_TRIG == 0) || (state == S_POST && last_post)) begin
                  state        <= S_DUMP;
                  bus.tx_valid <= 1'b1;
                  bus.tx_data  <= 8'hA5;
                  in_hdr       <= 1'b1;
                  hdr_pos      <= 2'd0;
               end else if (state == S_ARMED && trig) begin
                  state <= S_POST;
               end else if (state == S_POST && bus.rvfi_valid) begin
                  post_cnt <= post_cnt + 16'd1;
               end
            end
            S_DUMP: begin
               if (xfer) begin
                  if (in_hdr && hdr_pos != 2'd2) begin
                     hdr_pos     <= hdr_pos + 2'd1;
                     bus.tx_data <= (hdr_pos == 2'd0) ? count[7:0] : count[15:8];
                  end else if (last_byte) begin
                     state        <= S_DONE;
                     bus.tx_valid <= 1'b0;
                     bus.tx_data  <= 8'h00;
                  end else begin
                     bus.tx_data <= rec_byte;
                     byte_sel    <= nxt_sel;
                     rd_ptr      <= rd_addr;
                     if (in_hdr) begin
                        in_hdr    <= 1'b0;
                        recs_left <= count;
                     end else if (byte_sel == 4'd8) begin
                        recs_left <= recs_left - 16'd1;
                     end
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign armed     = (state == S_ARMED);
   assign triggered = (state == S_POST);
   assign busy      = (state == S_DUMP);
   assign done      = (state == S_DONE);
endmodule

// File: tb/tb_rvfi_trace_capture.sv
// Bench for rvfi_trace_capture: three parameterisations share one stimulus bus;
// a queue-based trace model predicts status and the dumped byte stream.
module tb_rvfi_trace_capture;
   typedef enum int {M_IDLE, M_ARMED, M_POST, M_DUMP, M_DONE} mphase_t;
   typedef struct {
      bit        arm;
      bit        frc;
      bit [2:0]  mask;
      bit        v;
      bit [2:0]  flags;
      bit [31:0] pc;
      bit [3:0]  exp_st;   // {done, busy, triggered, armed}
   } vec_t;

   localparam logic [7:0] PC34 [4] = '{8'h14, 8'h18, 8'h1C, 8'h20};
   localparam logic [7:0] FL34 [4] = '{8'h00, 8'h00, 8'h01, 8'h00};

   logic        sys_clock = 1'b0;
   logic        reset = 1'b1;
   logic        arm = 1'b0, force_trig = 1'b0, tx_ready = 1'b0;
   logic [2:0]  trig_mask = '0, fl = '0;
   logic        rv = 1'b0;
   logic [31:0] pc = '0, insn = '0;
   logic [3:0]  st_a, st_b, st_c;

   always #5 sys_clock = ~sys_clock;

   rvfi_trace_capture_if if_a ();
   rvfi_trace_capture_if if_b ();
   rvfi_trace_capture_if if_c ();

   assign if_a.rvfi_valid = rv;  assign if_b.rvfi_valid = rv;  assign if_c.rvfi_valid = rv;
   assign if_a.rvfi_pc_rdata = pc;  assign if_b.rvfi_pc_rdata = pc;  assign if_c.rvfi_pc_rdata = pc;
   assign if_a.rvfi_insn = insn;  assign if_b.rvfi_insn = insn;  assign if_c.rvfi_insn = insn;
   assign if_a.rvfi_trap = fl[0];  assign if_b.rvfi_trap = fl[0];  assign if_c.rvfi_trap = fl[0];
   assign if_a.rvfi_halt = fl[1];  assign if_b.rvfi_halt = fl[1];  assign if_c.rvfi_halt = fl[1];
   assign if_a.rvfi_intr = fl[2];  assign if_b.rvfi_intr = fl[2];  assign if_c.rvfi_intr = fl[2];
   assign if_a.tx_ready = tx_ready;  assign if_b.tx_ready = tx_ready;  assign if_c.tx_ready = tx_ready;

   rvfi_trace_capture #(.DEPTH(64), .POST_TRIG(16)) u_a (
      .sys_clock(sys_clock), .reset(reset), .bus(if_a), .arm(arm), .force_trig(force_trig),
      .trig_mask(trig_mask), .armed(st_a[0]), .triggered(st_a[1]), .busy(st_a[2]), .done(st_a[3]));
   rvfi_trace_capture #(.DEPTH(4), .POST_TRIG(1)) u_b (
      .sys_clock(sys_clock), .reset(reset), .bus(if_b), .arm(arm), .force_trig(force_trig),
      .trig_mask(trig_mask), .armed(st_b[0]), .triggered(st_b[1]), .busy(st_b[2]), .done(st_b[3]));
   rvfi_trace_capture #(.DEPTH(8), .POST_TRIG(0)) u_c (
      .sys_clock(sys_clock), .reset(reset), .bus(if_c), .arm(arm), .force_trig(force_trig),
      .trig_mask(trig_mask), .armed(st_c[0]), .triggered(st_c[1]), .busy(st_c[2]), .done(st_c[3]));

   int          sel = 0;
   logic        cur_v;
   logic [7:0]  cur_d;
   logic [3:0]  cur_st;

   always_comb begin
      cur_v  = if_a.tx_valid;
      cur_d  = if_a.tx_data;
      cur_st = st_a;
      if (sel == 1) begin
         cur_v  = if_b.tx_valid;
         cur_d  = if_b.tx_data;
         cur_st = st_b;
      end else if (sel == 2) begin
         cur_v  = if_c.tx_valid;
         cur_d  = if_c.tx_data;
         cur_st = st_c;
      end
   end

   // Reference model: captured records as a bounded queue, stream built from it.
   mphase_t     m_phase = M_IDLE;
   int          m_depth = 64, m_post = 16, m_left = 0;
   logic [66:0] m_buf[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  got[$];
   int          n_checks = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic use_dut(input int s);
      sel = s;
      case (s)
         0:       begin m_depth = 64; m_post = 16; end
         1:       begin m_depth = 4;  m_post = 1;  end
         default: begin m_depth = 8;  m_post = 0;  end
      endcase
      #1;
   endtask

   task automatic model_reset();
      m_phase = M_IDLE;
      m_buf.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1; arm = 1'b0; force_trig = 1'b0; rv = 1'b0; tx_ready = 1'b0;
      repeat (2) @(negedge sys_clock);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic push_rec(input logic [66:0] rec);
      m_buf.push_back(rec);
      if (m_buf.size() > m_depth) void'(m_buf.pop_front());
   endtask

   task automatic model_cycle(input bit a, input bit f, input bit [2:0] mask, input bit v,
                              input logic [66:0] rec);
      case (m_phase)
         M_IDLE, M_DONE: if (a) begin m_phase = M_ARMED; m_buf.delete(); end
         M_ARMED: begin
            if (v) push_rec(rec);
            if (f || (v && (mask & rec[66:64]) != 3'b000)) begin
               m_left  = m_post;
               m_phase = (m_post == 0) ? M_DUMP : M_POST;
            end
         end
         M_POST: if (v) begin
            push_rec(rec);
            m_left--;
            if (m_left == 0) m_phase = M_DUMP;
         end
         default: ;
      endcase
   endtask

   task automatic check_status(input string name);
      logic [3:0] e;
      e = 4'b0000;
      case (m_phase)
         M_ARMED: e = 4'b0001;
         M_POST:  e = 4'b0010;
         M_DUMP:  e = 4'b0100;
         M_DONE:  e = 4'b1000;
         default: e = 4'b0000;
      endcase
      check(name, cur_st, e);
   endtask

   task automatic drive(input bit a, input bit f, input bit [2:0] mask, input bit v,
                        input bit [2:0] flg, input bit [31:0] p, input bit [31:0] ins);
      arm = a; force_trig = f; trig_mask = mask; rv = v; fl = flg; pc = p; insn = ins;
      model_cycle(a, f, mask, v, {flg, p, ins});
      @(negedge sys_clock);
      arm = 1'b0; force_trig = 1'b0; rv = 1'b0;
      check_status("status");
   endtask

   task automatic build_exp();
      int n;
      logic [66:0] r;
      exp_q.delete();
      n = m_buf.size();
      exp_q.push_back(8'hA5);
      exp_q.push_back(n[7:0]);
      exp_q.push_back(n[15:8]);
      foreach (m_buf[i]) begin
         r = m_buf[i];
         exp_q.push_back({5'b0, r[66:64]});
         for (int b = 0; b < 4; b++) exp_q.push_back(r[32 + 8*b +: 8]);
         for (int b = 0; b < 4; b++) exp_q.push_back(r[8*b +: 8]);
      end
   endtask

   task automatic collect(input bit rnd, input string name);
      bit         pend = 1'b0;
      logic [7:0] held = '0;
      int         cyc = 0, first = -1;
      got.delete();
      build_exp();
      while (cur_st[3] !== 1'b1 && cyc < 4000) begin
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         check("valid_only_in_dump", cur_v & ~cur_st[2], 1'b0);
         if (pend) begin
            check("stall_valid", cur_v, 1'b1);
            check("stall_data", cur_d, held);
         end
         if (cur_v === 1'b1) begin
            if (first < 0) first = cyc;
            if (tx_ready) begin
               got.push_back(cur_d);
               pend = 1'b0;
            end else begin
               pend = 1'b1;
               held = cur_d;
            end
         end
         @(negedge sys_clock);
         cyc++;
      end
      tx_ready = 1'b0;
      check({name, "_done"}, cur_st, 4'b1000);
      check({name, "_valid_after"}, cur_v, 1'b0);
      check({name, "_first_lat"}, (first >= 0 && first <= 3), 1'b1);
      if (!rnd) check({name, "_rate"}, (cyc <= 2 * got.size() + 2), 1'b1);
      check({name, "_len"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) check({name, "_byte"}, got[i], exp_q[i]);
      m_phase = M_DONE;
   endtask

   task automatic random_capture();
      int guard = 0;
      drive(1'b1, 1'b0, 3'($urandom), 1'b1, 3'($urandom), $urandom, $urandom);
      while (m_phase != M_DUMP && guard < 3000) begin
         drive(1'($urandom_range(0, 15) == 0),
               (guard > 150) ? 1'b1 : 1'($urandom_range(0, 63) == 0),
               3'($urandom),
               1'($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000,
               $urandom, $urandom);
         guard++;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [10];
      int   n, g;
      vt[0] = '{1'b1, 1'b0, 3'b001, 1'b0, 3'b000, 32'h0, 4'b0001};
      for (int i = 1; i < 8; i++) vt[i] = '{1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 32'(4 * (i - 1)), 4'b0001};
      vt[8] = '{1'b0, 1'b0, 3'b001, 1'b1, 3'b001, 32'h1C, 4'b0010};
      vt[9] = '{1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 32'h20, 4'b0100};

      // Outputs while reset is held.
      repeat (2) @(negedge sys_clock);
      for (int s = 0; s < 3; s++) begin
         use_dut(s);
         check("rst_status", cur_st, 4'b0000);
         check("rst_tx_valid", cur_v, 1'b0);
         check("rst_tx_data", cur_d, 8'h00);
      end
      @(negedge sys_clock);

      // Default parameters: 10 retires, force trigger, 16 post records.
      use_dut(0); do_reset();
      drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 32'h100 + 32'(4 * i), $urandom);
      drive(1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 32'h200 + 32'(4 * i), $urandom);
      collect(1'b0, "d33");
      check("d33_hdr0", got[0], 8'hA5);
      check("d33_hdr1", got[1], 8'h1A);
      check("d33_hdr2", got[2], 8'h00);
      check("d33_pc0", got[4], 8'h00);
      check("d33_pc1", got[5], 8'h01);
      check("d33_pc2", got[6], 8'h00);
      check("d33_pc3", got[7], 8'h00);

      // DEPTH=4 wrap with a trap trigger, table driven.
      use_dut(1); do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].arm, vt[i].frc, vt[i].mask, vt[i].v, vt[i].flags, vt[i].pc, 32'hC0DE_0000 | vt[i].pc);
         check("vec_status", cur_st, vt[i].exp_st);
      end
      collect(1'b0, "d34");
      check("d34_hdr0", got[0], 8'hA5);
      check("d34_hdr1", got[1], 8'h04);
      check("d34_hdr2", got[2], 8'h00);
      for (int k = 0; k < 4; k++) begin
         check("d34_flags", got[3 + 9 * k], FL34[k]);
         check("d34_pc", got[4 + 9 * k], PC34[k]);
      end

      // Random captures with backpressure, re-armed from DONE.
      for (int d = 0; d < 2; d++) begin
         use_dut(d); do_reset();
         for (int it = 0; it < 3; it++) begin
            random_capture();
            collect(1'b1, "rnd");
         end
      end

      // Arm coincident with a trap retire: not stored, no trigger.
      use_dut(0); do_reset();
      drive(1'b1, 1'b0, 3'b001, 1'b1, 3'b001, 32'h4000, 32'h1);
      check("arm_trap_no_trig", cur_st, 4'b0001);
      drive(1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 32'h4004, 32'h2);
      drive(1'b0, 1'b0, 3'b001, 1'b1, 3'b001, 32'h4008, 32'h3);
      check("trap_trig", cur_st, 4'b0010);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 3'b001, 1'b1, 3'b001, 32'h4100 + 32'(4 * i), $urandom);
      collect(1'b0, "d36");
      check("d36_count", got[1], 8'd18);
      check("d36_first_pc0", got[4], 8'h04);
      check("d36_first_pc1", got[5], 8'h40);

      // Reset while the 5th dump byte is presented, then a fresh capture.
      use_dut(0); do_reset();
      drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 32'h500 + 32'(4 * i), $urandom);
      drive(1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 32'h600 + 32'(4 * i), $urandom);
      tx_ready = 1'b1; n = 0; g = 0;
      while (n < 4 && g < 100) begin
         if (cur_v === 1'b1) n++;
         @(negedge sys_clock);
         g++;
      end
      check("d37_fifth_valid", cur_v, 1'b1);
      reset = 1'b1; arm = 1'b1;
      @(negedge sys_clock);
      check("d37_rst_valid", cur_v, 1'b0);
      check("d37_rst_data", cur_d, 8'h00);
      check("d37_rst_status", cur_st, 4'b0000);
      reset = 1'b0; arm = 1'b0; tx_ready = 1'b0;
      model_reset();
      drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 32'h700 + 32'(4 * i), $urandom);
      drive(1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 32'h800 + 32'(4 * i), $urandom);
      collect(1'b0, "d37");
      check("d37_count", got[1], 8'd18);

      // POST_TRIG=0, force right after arm: header only.
      use_dut(2); do_reset();
      drive(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 3'b000, 1'b0, 3'b000, 32'h0, 32'h0);
      collect(1'b0, "d38");
      check("d38_len", got.size(), 3);
      check("d38_b0", got[0], 8'hA5);
      check("d38_b1", got[1], 8'h00);
      check("d38_b2", got[2], 8'h00);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
